window_gen3x3: RTL

Streaming 3x3 window generator feeding the convolution unit. Accepts an image one pixel per transfer in raster order, buffers the two previous rows internally, and presents each complete 3x3 neighbourhood as nine parallel words (w00..w22) matching the a00..a22 operand ordering of the conv unit. Performs valid-mode windowing (no padding): an IMG_W x IMG_H frame yields (IMG_W-2) x (IMG_H-2) windows.

---
 rtl/window_gen3x3_pkg.sv | 12 +
 rtl/window_gen3x3_line_buf.sv | 22 ++
 rtl/window_gen3x3.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/window_gen3x3_pkg.sv
// Shared definitions for the streaming 3x3 window generator.
package window_gen3x3_pkg;

  localparam int WIN_DIM  = 3;
  localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } wg_state_e;

endpackage

// File: rtl/window_gen3x3_line_buf.sv
// Single-port row buffer: combinational read of the addressed word, write on the clock edge,
// so a read and write to the same address in one cycle returns the old contents.
module window_gen3x3_line_buf #(
  parameter int DEPTH  = 28,
  parameter int DATA_W = 9
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/window_gen3x3.sv
// Streaming valid-mode 3x3 window generator (raster pixels in, nine parallel taps out).
// Optional WINGEN_LAST_EN adds a win_last flag on the final window of each frame.
module window_gen3x3
  import window_gen3x3_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [WIDTH-1:0] pix_in,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [WIDTH-1:0] w00,
  output logic [WIDTH-1:0] w01,
  output logic [WIDTH-1:0] w02,
  output logic [WIDTH-1:0] w10,
  output logic [WIDTH-1:0] w11,
  output logic [WIDTH-1:0] w12,
  output logic [WIDTH-1:0] w20,
  output logic [WIDTH-1:0] w21,
  output logic [WIDTH-1:0] w22,
  output logic             frame_done
`ifdef WINGEN_LAST_EN
  ,
  output logic             win_last
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic             accept, last_col, last_row, emit;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  wg_state_e        state_q, state_d;
  logic [WIDTH-1:0] lb0_rd, lb1_rd;
  logic [WIDTH-1:0] win_p1_q [WIN_DIM][WIN_DIM];
  logic [WIDTH-1:0] win_p1_d [WIN_DIM][WIN_DIM];
  logic             vld_p1_q, vld_p1_d;
  logic             done_q, done_d;

  assign pix_ready = !vld_p1_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign last_col  = (col_q == CW'(IMG_W - 1));
  assign last_row  = (row_q == RW'(IMG_H - 1));
  // Columns 0 and 1 of every row only prime the shift window.
  assign emit      = accept && (state_q == RUN) && (col_q >= CW'(2));

  // LB0 takes the row leaving LB1, so LB0 always lags LB1 by one row.
  window_gen3x3_line_buf #(.DEPTH(IMG_W), .DATA_W(WIDTH)) u_lb0 (
    .clk_i  (clk),
    .we_i   (accept),
    .addr_i (col_q),
    .wdata_i(lb1_rd),
    .rdata_o(lb0_rd)
  );

  window_gen3x3_line_buf #(.DEPTH(IMG_W), .DATA_W(WIDTH)) u_lb1 (
    .clk_i  (clk),
    .we_i   (accept),
    .addr_i (col_q),
    .wdata_i(pix_in),
    .rdata_o(lb1_rd)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && last_col && (row_q == RW'(1))) state_d = RUN;
      RUN:     if (accept && last_col && last_row)          state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    win_p1_d = win_p1_q;
    vld_p1_d = vld_p1_q;
    done_d   = accept && last_col && last_row;
    if (accept) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        for (int c = 0; c < WIN_DIM - 1; c++) begin
          win_p1_d[r][c] = win_p1_q[r][c+1];
        end
      end
      win_p1_d[0][WIN_DIM-1] = lb0_rd;
      win_p1_d[1][WIN_DIM-1] = lb1_rd;
      win_p1_d[2][WIN_DIM-1] = pix_in;
      vld_p1_d = emit;
    end else if (win_ready) begin
      vld_p1_d = 1'b0;
    end
  end

  // ---- p1: registered window stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      state_q  <= FILL;
      vld_p1_q <= 1'b0;
      done_q   <= 1'b0;
      win_p1_q <= '{default: '0};
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      state_q  <= state_d;
      vld_p1_q <= vld_p1_d;
      done_q   <= done_d;
      win_p1_q <= win_p1_d;
    end
  end

`ifdef WINGEN_LAST_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (accept)         last_d = done_d;
    else if (win_ready) last_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= last_d;
  end

  assign win_last = last_q;
`endif

  assign win_valid  = vld_p1_q;
  assign frame_done = done_q;
  assign w00 = win_p1_q[0][0];
  assign w01 = win_p1_q[0][1];
  assign w02 = win_p1_q[0][2];
  assign w10 = win_p1_q[1][0];
  assign w11 = win_p1_q[1][1];
  assign w12 = win_p1_q[1][2];
  assign w20 = win_p1_q[2][0];
  assign w21 = win_p1_q[2][1];
  assign w22 = win_p1_q[2][2];

endmodule
